// File: rtl/switch_debounce.sv
// switch_debounce
// Conditions raw, asynchronous board switch levels for the clk domain.
// Each channel has its own multi-flop synchronizer, confirm counter and a
// four-state FSM. A level change is accepted only after DEBOUNCE_CYCLES
// consecutive synchronized samples agree on the new value. One opposite
// sample abandons the candidate change and the confirmation starts again.
// The outputs sw_db and busy are registered and decoded from the next state.
// No combinational path runs from sw_raw to any output.

module switch_debounce #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] busy
);

    // The encoding is chosen so that bit 1 is the accepted level and bit 0
    // marks a pending confirmation. The output decode is still written out
    // explicitly below so that it never depends on this encoding.
    typedef enum logic [1:0] {
        ST_LO = 2'b00,
        CF_HI = 2'b01,
        ST_HI = 2'b10,
        CF_LO = 2'b11
    } state_t;

    // The last count value that still needs one more agreeing sample. With
    // CNT_W = clog2(DEBOUNCE_CYCLES) this always fits, and the counter
    // never needs to go past it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            state_t                 state_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic                   sw_db_reg;
            logic                   busy_reg;

            // Synchronizer chain: sw_raw enters at bit 0 and s is taken
            // from the last stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw_raw[gi]};
                end
            end

            assign s = sync_reg[SYNC_STAGES-1];

            // Debounce FSM. The confirm counter and the registered outputs
            // are updated on the same edge as the state they decode from.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_LO;
                    cnt_reg   <= '0;
                    sw_db_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end else begin
                    case (state_reg)
                        ST_LO: begin
                            if (s) begin
                                state_reg <= CF_HI;
                                cnt_reg   <= CNT_ONE;
                                sw_db_reg <= 1'b0;
                                busy_reg  <= 1'b1;
                            end else begin
                                cnt_reg   <= '0;
                                sw_db_reg <= 1'b0;
                                busy_reg  <= 1'b0;
                            end
                        end

                        CF_HI: begin
                            if (!s) begin
                                // Glitch rejected: fall back and forget the count.
                                state_reg <= ST_LO;
                                cnt_reg   <= '0;
                                sw_db_reg <= 1'b0;
                                busy_reg  <= 1'b0;
                            end else if (cnt_reg == CNT_LAST) begin
                                // This sample is the DEBOUNCE_CYCLES-th agreeing one.
                                state_reg <= ST_HI;
                                cnt_reg   <= '0;
                                sw_db_reg <= 1'b1;
                                busy_reg  <= 1'b0;
                            end else begin
                                cnt_reg   <= cnt_reg + CNT_ONE;
                                sw_db_reg <= 1'b0;
                                busy_reg  <= 1'b1;
                            end
                        end

                        ST_HI: begin
                            if (!s) begin
                                state_reg <= CF_LO;
                                cnt_reg   <= CNT_ONE;
                                sw_db_reg <= 1'b1;
                                busy_reg  <= 1'b1;
                            end else begin
                                cnt_reg   <= '0;
                                sw_db_reg <= 1'b1;
                                busy_reg  <= 1'b0;
                            end
                        end

                        CF_LO: begin
                            if (s) begin
                                state_reg <= ST_HI;
                                cnt_reg   <= '0;
                                sw_db_reg <= 1'b1;
                                busy_reg  <= 1'b0;
                            end else if (cnt_reg == CNT_LAST) begin
                                state_reg <= ST_LO;
                                cnt_reg   <= '0;
                                sw_db_reg <= 1'b0;
                                busy_reg  <= 1'b0;
                            end else begin
                                cnt_reg   <= cnt_reg + CNT_ONE;
                                sw_db_reg <= 1'b1;
                                busy_reg  <= 1'b1;
                            end
                        end

                        default: begin
                            state_reg <= ST_LO;
                            cnt_reg   <= '0;
                            sw_db_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                        end
                    endcase
                end
            end

            assign sw_db[gi] = sw_db_reg;
            assign busy[gi]  = busy_reg;
        end
    endgenerate

endmodule

// File: tb/tb_switch_debounce.sv
// Testbench for switch_debounce with WIDTH=2, DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
// Hand-written sequences and a vector table check the documented latencies.
// A reference model checks every cycle, including a randomized phase. The
// model treats each channel as a count of consecutive synchronized samples
// that disagree with the accepted level. The level flips when that count
// reaches DEBOUNCE_CYCLES.

module tb_switch_debounce;

    localparam int W    = 2;
    localparam int DEB  = 8;
    localparam int SYNC = 2;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_db;
    logic [W-1:0] busy;

    int checks   = 0;
    int failures = 0;

    switch_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .sw_db(sw_db),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist_q[k] holds the raw value that was sampled k+1 edges ago. The FSM
    // sees the raw value from SYNC edges back.
    logic [W-1:0] hist_q[$];
    logic [W-1:0] m_db;
    int           m_run[W];

    function automatic void model_reset();
        hist_q.delete();
        for (int i = 0; i < SYNC; i++) hist_q.push_back('0);
        m_db = '0;
        for (int c = 0; c < W; c++) m_run[c] = 0;
    endfunction

    function automatic void model_edge(input logic [W-1:0] raw_now);
        logic [W-1:0] seen;
        seen = hist_q[SYNC-1];
        hist_q.push_front(raw_now);
        void'(hist_q.pop_back());
        for (int c = 0; c < W; c++) begin
            if (seen[c] != m_db[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_db[c]  = ~m_db[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
    endfunction

    function automatic logic [W-1:0] model_busy();
        logic [W-1:0] b;
        for (int c = 0; c < W; c++) b[c] = (m_run[c] != 0);
        return b;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge. Inputs are stable here, so the model advances with
    // them first. The DUT is then sampled 1 time unit after the edge.
    task automatic step();
        if (rst_n) model_edge(sw_raw);
        @(posedge clk);
        #1;
        if (rst_n) begin
            check("model_db", sw_db, m_db);
            check("model_busy", busy, model_busy());
        end
    endtask

    // Reset is asserted mid-cycle and the outputs are checked before any
    // edge. Reset is then held over two edges and released away from the edge.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_db", sw_db, '0);
        check("rst_async_busy", busy, '0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_db", sw_db, '0);
            check("rst_hold_busy", busy, '0);
        end
        rst_n = 1'b1;
    endtask

    // Counts the edges until sw_db[ch] reaches lvl. Edge 1 is the first
    // edge after the call.
    task automatic wait_db(input int ch, input logic lvl, input int exp_steps, input string name);
        int n;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (sw_db[ch] == lvl) begin
                n = k;
                break;
            end
        end
        check_int(name, n, exp_steps);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] db;
        logic [W-1:0] bsy;
    } vec_t;

    vec_t tbl[11];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int bcount;
        int fell;
        int rose;

        model_reset();

        // Clean press on channel 0, one row per edge starting at edge R.
        tbl[0]  = '{raw: 2'b01, db: 2'b00, bsy: 2'b00};
        tbl[1]  = '{raw: 2'b01, db: 2'b00, bsy: 2'b00};
        for (int i = 2; i <= 8; i++) tbl[i] = '{raw: 2'b01, db: 2'b00, bsy: 2'b01};
        tbl[9]  = '{raw: 2'b01, db: 2'b01, bsy: 2'b00};
        tbl[10] = '{raw: 2'b01, db: 2'b01, bsy: 2'b00};

        // Power-up with both switches held high: reset mid-cycle, then
        // the rise comes at edge 10 counting the first release edge as 1.
        sw_raw = 2'b11;
        reset_pulse();
        wait_db(0, 1'b1, 10, "powerup_rise");
        check("powerup_both", sw_db, 2'b11);

        // Release channel 1 only. Channel 0 must stay high.
        sw_raw = 2'b01;
        wait_db(1, 1'b0, 10, "release_ch1_fall");
        check("indep_ch0_high", sw_db, 2'b01);

        // 7-cycle low glitch on channel 0 must not be accepted.
        bcount = 0;
        fell   = 0;
        sw_raw = 2'b00;
        for (int k = 0; k < 17; k++) begin
            if (k == 7) sw_raw = 2'b01;
            step();
            if (busy[0]) bcount++;
            if (!sw_db[0]) fell = 1;
        end
        check_int("glitch_busy_cycles", bcount, 7);
        check_int("glitch_db_fell", fell, 0);

        // Release channel 0, then run the clean-press table.
        sw_raw = 2'b00;
        wait_db(0, 1'b0, 10, "release_ch0_fall");
        for (int i = 0; i < 11; i++) begin
            sw_raw = tbl[i].raw;
            step();
            check($sformatf("tbl_db[%0d]", i), sw_db, tbl[i].db);
            check($sformatf("tbl_busy[%0d]", i), busy, tbl[i].bsy);
        end

        // Bounce: 3 cycles per level, 1,0,1,0, then hold 1.
        sw_raw = 2'b00;
        wait_db(0, 1'b0, 10, "pre_bounce_fall");
        rose = 0;
        for (int j = 0; j < 12; j++) begin
            sw_raw = ((j / 3) % 2 == 0) ? 2'b01 : 2'b00;
            step();
            if (sw_db[0]) rose = 1;
        end
        check_int("bounce_db_rose", rose, 0);
        sw_raw = 2'b01;
        wait_db(0, 1'b1, 10, "bounce_final_rise");

        // Reset in the middle of a confirmation (count at 5).
        sw_raw = 2'b00;
        wait_db(0, 1'b0, 10, "pre_midrst_fall");
        sw_raw = 2'b01;
        repeat (7) step();
        check("midrst_busy_before", busy, 2'b01);
        reset_pulse();
        step();
        step();
        check("restart_busy_idle", busy, 2'b00);
        step();
        check("restart_busy_on", busy, 2'b01);
        wait_db(0, 1'b1, 7, "restart_rise");

        // Random levels. Each channel toggles rarely, so some changes are
        // confirmed and others are rejected as glitches.
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(6) == 0) sw_raw[c] = ~sw_raw[c];
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Upstream conditioning stage for the PalmPilot X switch/button inputs. It takes raw, asynchronous board switch levels, synchronizes them into the `clk` domain and filters contact bounce. It outputs a clean debounced level per channel that feeds the rising-edge pulse generator directly. Each channel is independent: it has its own synchronizer, confirm counter and 4-state FSM.

## Interface
- `WIDTH`, default 1: number of independent switch channels.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples required to accept a change (10 ms at 100 MHz). Legal range is at least 2.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth. Legal range is at least 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: confirm-counter width. Derived from `DEBOUNCE_CYCLES`; never overridden.
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: reset, asynchronous and active-low.
- `sw_raw` in WIDTH: raw switch levels, asynchronous to `clk`.
- `sw_db` out WIDTH: debounced level per channel. Registered.
- `busy` out WIDTH: per channel, high while a candidate change is being confirmed. Registered.

## Operation
- **Synchronizer:** `sw_raw[i]` passes through a `SYNC_STAGES`-deep register chain. The last stage is called `s[i]`. Only `s[i]` is used downstream.
- **FSM states per channel:**
  - `ST_LO`: `sw_db=0`, `busy=0`.
  - `CF_HI`: `sw_db=0`, `busy=1`.
  - `ST_HI`: `sw_db=1`, `busy=0`.
  - `CF_LO`: `sw_db=1`, `busy=1`.
- **Transitions:** all are evaluated each `clk` rising edge.
  - `ST_LO`: if `s=1`, go to `CF_HI` and set `cnt=1`. Otherwise stay, with `cnt=0`.
  - `CF_HI`: if `s=0`, go to `ST_LO` and clear `cnt` (glitch rejected). If `s=1` and `cnt==DEBOUNCE_CYCLES-1`, go to `ST_HI`, clear `cnt` and set `sw_db=1`. Otherwise increment `cnt`.
  - `ST_HI` and `CF_LO`: mirror images of the above with polarity inverted.
- A change is therefore accepted only after `DEBOUNCE_CYCLES` consecutive edges sample the new `s` value. A single opposite sample restarts the confirmation from scratch.
- **Counter bounds:** `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps. It is 0 in both stable states.
- **Registered outputs:** `sw_db` and `busy` are decoded from the next state and registered, so they are glitch-free.
- **Channel independence:** no channel's behaviour depends on any other channel.
- **Reset values** (asynchronous assert on `rst_n=0`):
  - all synchronizer stages = 0;
  - state = `ST_LO`, `cnt` = 0;
  - `sw_db` = 0, `busy` = 0.

  Deassertion is synchronous to `clk`; the top level provides a synchronized `rst_n` release.
- **Reset mid-confirmation:** the confirmation is abandoned and `sw_db` returns to 0 immediately. A switch that is held high after release is re-confirmed from scratch.
- **Switch high at power-up:** `sw_db` rises only after the full synchronizer plus debounce latency. As a result, the downstream pulse stage sees one rising edge after reset. This is intended.

## Timing
- **Latency:** let raw `sw_raw[i]` change and settle before edge R. Then:
  - `s[i]` reflects the change after edge R+`SYNC_STAGES`-1;
  - the FSM first samples it at edge R+`SYNC_STAGES` (enters `CF_*`, `busy` goes high);
  - `sw_db` toggles at edge R+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1 and `busy` falls on the same edge.
- With the defaults (`SYNC_STAGES=2`), total latency is `DEBOUNCE_CYCLES+1` edges after R.
- **Glitch rejection:** any raw pulse whose synchronized width is shorter than `DEBOUNCE_CYCLES` cycles never changes `sw_db`. `busy` pulses high for the glitch duration.
- **Minimum interval:** `sw_db` toggles at most once per `DEBOUNCE_CYCLES` cycles per channel.
- **No combinational path:** no combinational path exists from `sw_raw` to any output.

## Test plan
All scenarios use `WIDTH=2`, `DEBOUNCE_CYCLES=8`, `SYNC_STAGES=2`.
- **Reset:** hold `rst_n=0` with `sw_raw=2'b11`, asserting mid-cycle. Required: `sw_db=0` and `busy=0` immediately, before any clock edge. After release, `sw_db[0]` rises exactly 9 edges after the first post-release edge.
- **Clean press:** `sw_raw[0]` goes 0→1 before edge R and is held. Required: `busy[0]=1` from edge R+2, `sw_db[0]=1` at edge R+9, `busy[0]=0` at edge R+9. Channel 1 stays 0 throughout.
- **Bounce:** `sw_raw[0]` toggles 1,0,1,0 with a 3-cycle period, then holds 1. Required: `sw_db[0]` stays 0 during bouncing and rises 9 edges after the final 0→1 transition.
- **Sub-threshold glitch:** starting from `sw_db[0]=1`, drive `sw_raw[0]=0` for 7 cycles, then 1. Required: `sw_db[0]` never falls; `busy[0]` is high for 7 cycles.
- **Release and independence:** with both channels high, release channel 1 only. Required: `sw_db[1]` falls at R+9 and `sw_db[0]` remains 1.
- **Reset mid-confirm:** assert `rst_n=0` while `busy[0]=1` with `cnt=5`. Required: all outputs read 0 during reset, and confirmation restarts at `cnt=1` after release.
